// File: rtl/seq_shift_mul.sv
// Sequential signed shift-and-add multiplier: one partial product per RUN cycle,
// with the sign bit of the multiplier weighted negatively on the final step.
module seq_shift_mul #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int IW = (W > 2) ? $clog2(W) : 1;
   localparam logic [IW-1:0] LAST = IW'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [2*W-1:0]   a_q;
   logic [W-1:0]     b_q;
   logic [2*W-1:0]   acc_q;
   logic [2*W-1:0]   acc_d;
   logic [2*W-1:0]   term;
   logic [IW-1:0]    idx_q;
   logic             busy_q;
   logic             done_q;
   logic [2*W-1:0]   product_q;

   // Two's-complement weighting: the top multiplier bit contributes -2^(W-1).
   always_comb begin
      term  = a_q << idx_q;
      acc_d = acc_q;
      if (b_q[idx_q]) begin
         if (idx_q == LAST) begin
            acc_d = acc_q - term;
         end else begin
            acc_d = acc_q + term;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= {{W{a[W-1]}}, a};
                  b_q     <= b;
                  acc_q   <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               idx_q <= idx_q + IW'(1);
               if (idx_q == LAST) begin
                  product_q <= acc_d;
                  done_q    <= 1'b1;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_shift_mul.sv
// Self-checking bench for seq_shift_mul (W=4): directed cases, random operands,
// handshake protocol, asynchronous reset and a back-to-back exhaustive sweep.
module tb_seq_shift_mul;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [7:0] product;

   int errors = 0;
   int checks = 0;
   int busyCnt = 0;
   int doneCnt = 0;

   seq_shift_mul #(.W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (busy) busyCnt++;
      if (done) doneCnt++;
   end

   // Reference: plain signed integer multiplication truncated to 8 bits.
   function automatic logic [7:0] refMul(input logic [3:0] x, input logic [3:0] y);
      int sx;
      int sy;
      int p;
      sx = int'($signed(x));
      sy = int'($signed(y));
      p = sx * sy;
      return p[7:0];
   endfunction

   task automatic issue(input logic [3:0] ai, input logic [3:0] bi,
                        output int lat, output logic [7:0] prod, output bit timedOut);
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b1;
      a = ai;
      b = bi;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      lat = 0;
      prod = '0;
      timedOut = 1'b1;
      for (int i = 0; i < 12 && timedOut; i++) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) begin
            timedOut = 1'b0;
            prod = product;
         end
      end
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
      checks++;
      if (product !== 8'h00) begin errors++; $display("[TB] FAIL reset_product got=%h exp=00", product); end
      start = 1'b1;
      a = 4'd3;
      b = 4'd3;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_hold_busy got=%b exp=0", busy); end
      start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat;
      logic [7:0] prod;
      bit to;
      int busyBefore;
      int doneBefore;
      waitIdle();
      busyBefore = busyCnt;
      doneBefore = doneCnt;
      issue(4'd3, 4'd5, lat, prod, to);
      checks++;
      if (to || lat != 4) begin errors++; $display("[TB] FAIL basic_latency got=%0d timeout=%0b exp=4", lat, to); end
      checks++;
      if (prod !== 8'h0F) begin errors++; $display("[TB] FAIL basic_product got=%h exp=0f", prod); end
      waitIdle();
      checks++;
      if (busyCnt - busyBefore != 5) begin errors++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=5", busyCnt - busyBefore); end
      checks++;
      if (doneCnt - doneBefore != 1) begin errors++; $display("[TB] FAIL basic_done_pulses got=%0d exp=1", doneCnt - doneBefore); end
   endtask

   task automatic test_mixed();
      int lat;
      logic [7:0] prod;
      bit to;
      issue(4'hD, 4'd5, lat, prod, to);
      checks++;
      if (to || prod !== 8'hF1) begin errors++; $display("[TB] FAIL mixed_m3x5 got=%h exp=f1", prod); end
      issue(4'd7, 4'h8, lat, prod, to);
      checks++;
      if (to || prod !== 8'hC8) begin errors++; $display("[TB] FAIL mixed_7xm8 got=%h exp=c8", prod); end
   endtask

   task automatic test_extremes();
      int lat;
      logic [7:0] prod;
      bit to;
      issue(4'h8, 4'h8, lat, prod, to);
      checks++;
      if (to || prod !== 8'h40) begin errors++; $display("[TB] FAIL ext_m8xm8 got=%h exp=40", prod); end
      issue(4'h0, 4'hF, lat, prod, to);
      checks++;
      if (to || prod !== 8'h00) begin errors++; $display("[TB] FAIL ext_0xm1 got=%h exp=00", prod); end
      issue(4'hF, 4'hF, lat, prod, to);
      checks++;
      if (to || prod !== 8'h01) begin errors++; $display("[TB] FAIL ext_m1xm1 got=%h exp=01", prod); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      logic [7:0] prod;
      bit to;
      waitIdle();
      start = 1'b1;
      a = 4'd7;
      b = 4'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if (product !== 8'h00) begin errors++; $display("[TB] FAIL midrst_product got=%h exp=00", product); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%b exp=0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL midrst_done got=%b exp=0", done); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue(4'd7, 4'd7, lat, prod, to);
      checks++;
      if (to || lat != 4 || prod !== 8'h31) begin
         errors++;
         $display("[TB] FAIL midrst_restart got=%h lat=%0d exp=31 lat=4", prod, lat);
      end
   endtask

   task automatic test_busy_protocol();
      int guard;
      int doneBefore;
      int cyc;
      int accCyc;
      int prevAcc;
      int accepts;
      int dones;
      bit prevBusy;
      logic [3:0] accA;
      logic [3:0] accB;
      logic [7:0] lastProd;
      waitIdle();
      doneBefore = doneCnt;
      start = 1'b1;
      a = 4'd2;
      b = 4'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      a = 4'd5;
      b = 4'd5;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (product !== 8'h06) begin errors++; $display("[TB] FAIL busy_ignore_product got=%h exp=06", product); end
      checks++;
      if (doneCnt - doneBefore != 1) begin errors++; $display("[TB] FAIL busy_done_pulses got=%0d exp=1", doneCnt - doneBefore); end

      // Held start: operands re-randomised every cycle; the pair seen at acceptance is the one used.
      lastProd = 8'h06;
      prevBusy = busy;
      cyc = 0;
      accCyc = -100;
      prevAcc = -100;
      accepts = 0;
      dones = 0;
      accA = '0;
      accB = '0;
      a = 4'($urandom);
      b = 4'($urandom);
      start = 1'b1;
      while (dones < 5 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (busy && !prevBusy) begin
            accA = a;
            accB = b;
            prevAcc = accCyc;
            accCyc = cyc;
            accepts++;
            if (accepts > 1) begin
               checks++;
               if (accCyc - prevAcc != 6) begin errors++; $display("[TB] FAIL held_interval got=%0d exp=6", accCyc - prevAcc); end
            end
         end
         if (done) begin
            dones++;
            lastProd = refMul(accA, accB);
            checks++;
            if (product !== lastProd) begin errors++; $display("[TB] FAIL held_product a=%h b=%h got=%h exp=%h", accA, accB, product, lastProd); end
         end else begin
            checks++;
            if (product !== lastProd) begin errors++; $display("[TB] FAIL held_product_hold got=%h exp=%h", product, lastProd); end
         end
         prevBusy = busy;
         a = 4'($urandom);
         b = 4'($urandom);
      end
      start = 1'b0;
      checks++;
      if (dones != 5) begin errors++; $display("[TB] FAIL held_completions got=%0d exp=5", dones); end
   endtask

   task automatic test_random();
      int lat;
      logic [7:0] prod;
      logic [3:0] ra;
      logic [3:0] rb;
      bit to;
      for (int i = 0; i < 20; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         issue(ra, rb, lat, prod, to);
         checks++;
         if (to || lat != 4 || prod !== refMul(ra, rb)) begin
            errors++;
            $display("[TB] FAIL random a=%h b=%h got=%h lat=%0d exp=%h lat=4", ra, rb, prod, lat, refMul(ra, rb));
         end
      end
   endtask

   task automatic test_back_to_back();
      int k;
      int cyc;
      int accCyc;
      int prevAcc;
      int dones;
      bit prevBusy;
      logic [3:0] accA;
      logic [3:0] accB;
      logic [7:0] expProd;
      waitIdle();
      k = 0;
      cyc = 0;
      accCyc = -100;
      prevAcc = -100;
      dones = 0;
      accA = '0;
      accB = '0;
      prevBusy = busy;
      a = 4'(k >> 4);
      b = 4'(k);
      start = 1'b1;
      while (dones < 256 && cyc < 256 * 6 + 40) begin
         @(negedge clk);
         cyc++;
         if (busy && !prevBusy) begin
            accA = a;
            accB = b;
            prevAcc = accCyc;
            accCyc = cyc;
            if (k > 0) begin
               checks++;
               if (accCyc - prevAcc != 6) begin errors++; $display("[TB] FAIL sweep_interval k=%0d got=%0d exp=6", k, accCyc - prevAcc); end
            end
            k++;
            if (k < 256) begin
               a = 4'(k >> 4);
               b = 4'(k);
            end else begin
               start = 1'b0;
            end
         end
         if (done) begin
            dones++;
            expProd = refMul(accA, accB);
            checks++;
            if (product !== expProd || cyc - accCyc != 4) begin
               errors++;
               $display("[TB] FAIL sweep a=%h b=%h got=%h lat=%0d exp=%h lat=4", accA, accB, product, cyc - accCyc, expProd);
            end
         end
         prevBusy = busy;
      end
      start = 1'b0;
      checks++;
      if (dones != 256 || k != 256) begin
         errors++;
         $display("[TB] FAIL sweep_count done=%0d accepted=%0d exp=256", dones, k);
      end
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      #3;
      rst = 1'b1;
      test_reset();
      test_basic();
      test_mixed();
      test_extremes();
      test_reset_mid_run();
      test_busy_protocol();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
